// File: rtl/roi_pooler_pkg.sv
// Shared types and address helper for the ROI pooler.
package roi_pooler_pkg;

  typedef enum logic [1:0] {
    MODE_AVG = 2'd0,
    MODE_MAX = 2'd1,
    MODE_BIN = 2'd2,
    MODE_INV = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_FRAME,
    S_CAPTURE,
    S_FINISH
  } state_e;

  // Linear CNN-buffer address of cell (row, col) inside the zero border.
  function automatic int unsigned cnn_addr(input int unsigned row, input int unsigned col,
                                           input int unsigned pad, input int unsigned real_w);
    return (row + pad) * real_w + col + pad;
  endfunction

endpackage

// File: rtl/roi_pooler_lane.sv
// One ROI column: running sum/max of the current cell and its reduced result.
module pool_lane
  import roi_pooler_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int N     = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sel_i,
  input  logic             first_i,
  input  logic [PIX_W-1:0] pix_i,
  input  mode_e            mode_i,
  input  logic [PIX_W-1:0] thr_i,
  output logic [PIX_W-1:0] res_o
);

  localparam int LOG_N = $clog2(N);
  localparam int ACC_W = PIX_W + LOG_N;

  logic [ACC_W-1:0] sum_q, sum_d, base_sum;
  logic [PIX_W-1:0] max_q, max_d, base_max, cell_max, avg;
  logic [ACC_W:0]   total;
  logic [PIX_W:0]   avg_wide;

  // On the first pixel the old cell is discarded, so both load and accumulate share one adder.
  always_comb begin
    base_sum = first_i ? '0 : sum_q;
    base_max = first_i ? '0 : max_q;
    cell_max = (pix_i > base_max) ? pix_i : base_max;
    sum_d    = sum_q;
    max_d    = max_q;
    if (sel_i) begin
      sum_d = base_sum + ACC_W'(pix_i);
      max_d = cell_max;
    end
  end

  // Lane accumulator registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
      max_q <= '0;
    end else begin
      sum_q <= sum_d;
      max_q <= max_d;
    end
  end

  // Cell result including the current (last) pixel, rounded and saturated.
  always_comb begin
    total    = {1'b0, base_sum} + (ACC_W+1)'(pix_i) + (ACC_W+1)'(N / 2);
    avg_wide = total[ACC_W:LOG_N];
    avg      = avg_wide[PIX_W] ? '1 : avg_wide[PIX_W-1:0];
    unique case (mode_i)
      MODE_AVG: res_o = avg;
      MODE_MAX: res_o = cell_max;
      MODE_BIN: res_o = (avg >= thr_i) ? '1 : '0;
      MODE_INV: res_o = {PIX_W{1'b1}} - avg;
      default:  res_o = avg;
    endcase
  end

endmodule

// File: rtl/roi_pooler.sv
// Raster-driven ROI pooler: clears the CNN buffer, then reduces one frame's ROI cells into it.
module roi_pooler
  import roi_pooler_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int PIX_W   = 8,
  parameter int REC_W   = 8,
  parameter int REC_H   = 8,
  parameter int OUT_W   = 28,
  parameter int OUT_H   = 28,
  parameter int PAD     = 2,
  localparam int N      = REC_W * REC_H,
  localparam int ACC_W  = PIX_W + $clog2(N),
  localparam int REAL_W = OUT_W + 2 * PAD,
  localparam int REAL_H = OUT_H + 2 * PAD,
  localparam int OA_W   = $clog2(REAL_W * REAL_H)
) (
  input  logic             clk24,
  input  logic             rst,
  input  logic             start,
  input  logic [9:0]       cfg_left,
  input  logic [9:0]       cfg_top,
  input  logic [1:0]       cfg_mode,
  input  logic [PIX_W-1:0] cfg_thr,
  output logic [18:0]      pix_addr,
  input  logic [PIX_W-1:0] pix_in,
  output logic [OA_W-1:0]  out_addr,
  output logic [PIX_W-1:0] out_data,
  output logic             out_we,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             frame_end
);

  localparam int HC_W  = $clog2(H_TOTAL);
  localparam int VC_W  = $clog2(V_TOTAL);
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RWW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int ROI_W = OUT_W * REC_W;
  localparam int ROI_H = OUT_H * REC_H;

  state_e           state_q, state_d;
  logic [HC_W-1:0]  hor_q, hor_d, tag_hor_q;
  logic [VC_W-1:0]  ver_q, ver_d, tag_ver_q;
  logic [OA_W-1:0]  clr_q, out_addr_q, out_addr_d;
  logic [9:0]       left_q, top_q;
  mode_e            mode_q;
  logic [PIX_W-1:0] thr_q, out_data_q, out_data_d;
  logic             out_we_q, out_we_d, cfg_err_q;
  logic             roi_ok, in_roi, cap_pix, cell_first, cell_last;
  logic [CW-1:0]    cell_col;
  logic [RWW-1:0]   cell_row;
  logic [PIX_W-1:0] lane_res [OUT_W];

  assign frame_end = (hor_q == HC_W'(H_TOTAL - 1)) && (ver_q == VC_W'(V_TOTAL - 1));
  assign pix_addr  = ((int'(hor_q) < WIDTH) && (int'(ver_q) < HEIGHT))
                   ? 19'(hor_q) + 19'(ver_q) * 19'(WIDTH) : '0;
  assign roi_ok    = (int'(cfg_left) + ROI_W <= WIDTH) && (int'(cfg_top) + ROI_H <= HEIGHT);
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_we    = out_we_q;
  assign cfg_err   = cfg_err_q;

  // Raster counter next position, wrapping line then frame.
  always_comb begin
    hor_d = hor_q + 1'b1;
    ver_d = ver_q;
    if (hor_q == HC_W'(H_TOTAL - 1)) begin
      hor_d = '0;
      ver_d = (ver_q == VC_W'(V_TOTAL - 1)) ? '0 : ver_q + 1'b1;
    end
  end

  // Raster counters plus the one-cycle delayed copy that tags pix_in.
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      hor_q     <= '0;
      ver_q     <= '0;
      tag_hor_q <= '0;
      tag_ver_q <= '0;
    end else begin
      hor_q     <= hor_d;
      ver_q     <= ver_d;
      tag_hor_q <= hor_q;
      tag_ver_q <= ver_q;
    end
  end

  // Locate the tagged pixel within the ROI cell grid.
  always_comb begin
    int dx, dy;
    dx         = int'(tag_hor_q) - int'(left_q);
    dy         = int'(tag_ver_q) - int'(top_q);
    in_roi     = (dx >= 0) && (dx < ROI_W) && (dy >= 0) && (dy < ROI_H);
    cell_col   = CW'(dx / REC_W);
    cell_row   = RWW'(dy / REC_H);
    cell_first = ((dx % REC_W) == 0) && ((dy % REC_H) == 0);
    cell_last  = ((dx % REC_W) == REC_W - 1) && ((dy % REC_H) == REC_H - 1);
    cap_pix    = (state_q == S_CAPTURE) && in_roi;
  end

  for (genvar c = 0; c < OUT_W; c++) begin : g_lane
    pool_lane #(.PIX_W(PIX_W), .N(N)) u_lane (
      .clk_i   (clk24),
      .rst_i   (rst),
      .sel_i   (cap_pix && (cell_col == CW'(c))),
      .first_i (cell_first),
      .pix_i   (pix_in),
      .mode_i  (mode_q),
      .thr_i   (thr_q),
      .res_o   (lane_res[c])
    );
  end

  // FSM state register.
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (start && roi_ok) state_d = S_CLEAR;
      S_CLEAR:      if (clr_q == OA_W'(REAL_W * REAL_H - 1)) state_d = S_WAIT_FRAME;
      S_WAIT_FRAME: if (frame_end) state_d = S_CAPTURE;
      S_CAPTURE:    if (frame_end) state_d = S_FINISH;
      S_FINISH:     state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_FINISH);
  end

  // Next CNN-buffer write: border clear sweep or a finished cell.
  always_comb begin
    out_we_d   = 1'b0;
    out_addr_d = '0;
    out_data_d = '0;
    if (state_q == S_CLEAR) begin
      out_we_d   = 1'b1;
      out_addr_d = clr_q;
    end else if (cap_pix && cell_last) begin
      out_we_d   = 1'b1;
      out_addr_d = OA_W'(cnn_addr(int'(cell_row), int'(cell_col), PAD, REAL_W));
      out_data_d = lane_res[cell_col];
    end
  end

  // Configuration latch, clear counter and registered output port.
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      left_q     <= '0;
      top_q      <= '0;
      mode_q     <= MODE_AVG;
      thr_q      <= '0;
      clr_q      <= '0;
      cfg_err_q  <= 1'b0;
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      if (state_q == S_IDLE && start && roi_ok) begin
        left_q <= cfg_left;
        top_q  <= cfg_top;
        mode_q <= mode_e'(cfg_mode);
        thr_q  <= cfg_thr;
        clr_q  <= '0;
      end else if (state_q == S_CLEAR) begin
        clr_q <= clr_q + 1'b1;
      end
      cfg_err_q  <= (state_q == S_IDLE) && start && !roi_ok;
      out_we_q   <= out_we_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

endmodule
